// File: rtl/layer_seq_pkg.sv
// layer_seq_pkg: shared state encoding and sizing helpers for the layer sequencer.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package layer_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } seq_state_t;

    // Stage index width; a single-stage build still needs one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/layer_seq_ctrl_if.sv
// layer_seq_ctrl_if: command, layer handshake and status bundle of the layer sequencer.
// Latency: n/a (wiring only).
// Backpressure: n/a; layers stall the sequence through stage_fin.
interface layer_seq_ctrl_if #(
    parameter int NUM_STAGES = 5,
    parameter int GAP_W      = 16,
    parameter int TMO_W      = 32
);
    import layer_seq_pkg::*;

    localparam int IDX_W = idx_w(NUM_STAGES);

    logic                  en;
    logic                  start;
    logic                  load_we;
    logic                  abort;
    logic [GAP_W-1:0]      gap_cycles;
    logic [TMO_W-1:0]      tmo_cycles;
    logic [NUM_STAGES-1:0] stage_fin;
    logic [NUM_STAGES-1:0] stage_en;
    logic [IDX_W-1:0]      cur_stage;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        output en, start, load_we, abort, gap_cycles, tmo_cycles, stage_fin,
        input  stage_en, cur_stage, busy, done, error
    );

    modport slave (
        input  en, start, load_we, abort, gap_cycles, tmo_cycles, stage_fin,
        output stage_en, cur_stage, busy, done, error
    );

endinterface

// File: rtl/seq_gap_timer.sv
// seq_gap_timer: loadable down-counter that saturates at zero and flags it.
// Latency: load visible next cycle; zero flag is a decode of the count register.
// Backpressure: none; load has priority over decrement.
module seq_gap_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Count register: reload on request, otherwise count down and stick at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: after start and an input load, enables NUM_STAGES layers strictly one at a time.
// Latency: start->busy 1 cycle; fin->next enable 1+gap_cycles cycles; last fin->done 1 cycle.
// Backpressure: none; layers hold the sequence via stage_fin, abort overrides everything.
// Define LAYER_SEQ_WDOG_EN to add the per-stage watchdog and the ERR state.
module layer_seq_ctrl
    import layer_seq_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int GAP_W      = 16,
    parameter int TMO_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    layer_seq_ctrl_if.slave  bus
);

    localparam int               IDX_W    = idx_w(NUM_STAGES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    seq_state_t            state, state_nxt;
    logic [NUM_STAGES-1:0] stage_en, stage_en_nxt;
    logic [IDX_W-1:0]      cur_stage, cur_stage_nxt;
    logic [IDX_W-1:0]      nxt_idx;
    logic                  error, error_nxt;
    logic                  we_q;
    logic                  load_fall;
    logic                  fin_hit;
    logic                  gap_load, gap_zero;
    logic                  wd_load;
    logic                  tmo_hit;
    logic [GAP_W-1:0]      gap_init;

    // cur_stage always names the layer being run or the one just finished,
    // so the following layer is simply cur_stage + 1.
    assign nxt_idx   = cur_stage + IDX_W'(1);
    assign load_fall = we_q & ~bus.load_we;
    // Only the enabled layer's fin counts; stale fins from other layers are masked.
    assign fin_hit   = |(bus.stage_fin & stage_en);
    // Down-counter holds gap_cycles-1 so the GAP state lasts exactly gap_cycles cycles.
    assign gap_init  = bus.gap_cycles - GAP_W'(1);

    seq_gap_timer #(.W(GAP_W)) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (gap_load),
        .load_val (gap_init),
        .dec      (state == ST_GAP),
        .zero     (gap_zero)
    );

`ifdef LAYER_SEQ_WDOG_EN
    logic [TMO_W-1:0] tmo_init;
    logic             wd_zero;

    // Reloaded on every RUN entry; reaching zero means the layer has been
    // enabled for tmo_cycles cycles without a fin.
    assign tmo_init = bus.tmo_cycles - TMO_W'(1);
    assign tmo_hit  = (bus.tmo_cycles != '0) && wd_zero;

    seq_gap_timer #(.W(TMO_W)) u_wdog_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (wd_load),
        .load_val (tmo_init),
        .dec      (state == ST_RUN),
        .zero     (wd_zero)
    );
`else
    logic unused_wdog;

    assign tmo_hit     = 1'b0;
    assign unused_wdog = ^{bus.tmo_cycles, wd_load};
`endif

    // Next-state, enable, stage index and error decisions; abort pre-empts all of them.
    always_comb begin
        state_nxt     = state;
        stage_en_nxt  = stage_en;
        cur_stage_nxt = cur_stage;
        error_nxt     = error;
        gap_load      = 1'b0;
        wd_load       = 1'b0;
        if (bus.abort) begin
            state_nxt    = ST_IDLE;
            stage_en_nxt = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.start && bus.en) begin
                        state_nxt     = ST_LOAD;
                        cur_stage_nxt = '0;
                        error_nxt     = 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (!bus.en) begin
                        state_nxt = ST_IDLE;
                    end else if (load_fall) begin
                        state_nxt    = ST_RUN;
                        stage_en_nxt = NUM_STAGES'(1);
                        wd_load      = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (fin_hit) begin
                        stage_en_nxt = '0;
                        if (cur_stage == LAST_IDX) begin
                            state_nxt = ST_DONE;
                        end else if (bus.gap_cycles == '0) begin
                            stage_en_nxt  = NUM_STAGES'(1) << nxt_idx;
                            cur_stage_nxt = nxt_idx;
                            wd_load       = 1'b1;
                        end else begin
                            state_nxt = ST_GAP;
                            gap_load  = 1'b1;
                        end
                    end else if (tmo_hit) begin
                        state_nxt    = ST_ERR;
                        stage_en_nxt = '0;
                        error_nxt    = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_zero) begin
                        state_nxt     = ST_RUN;
                        stage_en_nxt  = NUM_STAGES'(1) << nxt_idx;
                        cur_stage_nxt = nxt_idx;
                        wd_load       = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_IDLE;
                end
                ST_ERR: begin
                    if (!bus.en) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, registered outputs and the load_we delay for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            stage_en  <= '0;
            cur_stage <= '0;
            error     <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            state     <= state_nxt;
            stage_en  <= stage_en_nxt;
            cur_stage <= cur_stage_nxt;
            error     <= error_nxt;
            we_q      <= bus.load_we;
        end
    end

    assign bus.stage_en  = stage_en;
    assign bus.cur_stage = cur_stage;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);
    assign bus.error     = error;

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// tb_layer_seq_ctrl: directed scenarios against a timing-rule model of the layer sequencer.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_layer_seq_ctrl;
    import layer_seq_pkg::*;

    localparam int N     = 5;
    localparam int IDX_W = idx_w(N);
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_GAP = 3, M_DONE = 4, M_ERR = 5;
`ifdef LAYER_SEQ_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] fin_base = '0;

    layer_seq_ctrl_if #(.NUM_STAGES(N), .GAP_W(16), .TMO_W(32)) dut_if ();

    layer_seq_ctrl #(.NUM_STAGES(N), .GAP_W(16), .TMO_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model: what the outputs must be, from the timing rules ----------------
    int   m_mode     = M_IDLE;
    int   m_active   = -1;     // enabled layer, -1 when none
    int   m_cur      = 0;
    bit   m_err      = 1'b0;
    int   m_gap_left = 0;      // zero-enable cycles still owed before the next layer
    int   m_age      = 0;      // cycles the current layer has been enabled without fin
    logic m_prev_we  = 1'b0;
    logic m_fell;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_mode = M_IDLE; m_active = -1; m_cur = 0; m_err = 1'b0;
            m_gap_left = 0; m_age = 0; m_prev_we = 1'b0;
        end else begin
            m_fell    = m_prev_we && !dut_if.load_we;
            m_prev_we = dut_if.load_we;
            if (dut_if.abort) begin
                m_mode = M_IDLE; m_active = -1;
            end else begin
                case (m_mode)
                    M_IDLE: if (dut_if.start && dut_if.en) begin
                        m_mode = M_LOAD; m_cur = 0; m_err = 1'b0;
                    end
                    M_LOAD: if (!dut_if.en) m_mode = M_IDLE;
                            else if (m_fell) begin m_mode = M_RUN; m_active = 0; m_age = 0; end
                    M_RUN: begin
                        if (dut_if.stage_fin[m_active]) begin
                            if (m_active == N - 1) begin
                                m_active = -1; m_mode = M_DONE;
                            end else if (dut_if.gap_cycles == 0) begin
                                m_active = m_active + 1; m_cur = m_active; m_age = 0;
                            end else begin
                                m_active = -1; m_mode = M_GAP; m_gap_left = int'(dut_if.gap_cycles);
                            end
                        end else begin
                            m_age++;
                            if (WDOG && dut_if.tmo_cycles != 0 && m_age == int'(dut_if.tmo_cycles)) begin
                                m_mode = M_ERR; m_active = -1; m_err = 1'b1;
                            end
                        end
                    end
                    M_GAP: begin
                        m_gap_left--;
                        if (m_gap_left == 0) begin
                            m_cur = m_cur + 1; m_active = m_cur; m_mode = M_RUN; m_age = 0;
                        end
                    end
                    M_DONE: m_mode = M_IDLE;
                    M_ERR:  if (!dut_if.en) m_mode = M_IDLE;
                    default: m_mode = M_IDLE;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    logic [N-1:0] e_en;
    initial forever begin
        @(negedge clk);
        e_en = (m_active >= 0) ? (N'(1) << m_active) : '0;
        chk("outputs",
            int'({dut_if.stage_en, dut_if.cur_stage, dut_if.busy, dut_if.done, dut_if.error}),
            int'({e_en, IDX_W'(m_cur), m_mode != M_IDLE, m_mode == M_DONE, m_err}));
    end

    // ---------------- observers for the hand-computed timing checks ----------------
    int           cyc = 0, zero_run = 0, done_cnt = 0, done_cyc = 0, busy_fall_cyc = 0;
    bit           seen = 1'b0;
    logic         prev_busy = 1'b0;
    logic [N-1:0] prev_en = '0;
    int           hi_len[N];
    int           cur_len[N];
    int           gaps[$];

    initial begin
        for (int k = 0; k < N; k++) begin hi_len[k] = 0; cur_len[k] = 0; end
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < N; k++) begin
                if (dut_if.stage_en[k]) cur_len[k]++;
                else if (cur_len[k] > 0) begin hi_len[k] = cur_len[k]; cur_len[k] = 0; end
            end
            if (dut_if.stage_en != '0) begin
                if (seen && dut_if.stage_en != prev_en) gaps.push_back(zero_run);
                zero_run = 0;
                seen = 1'b1;
            end else begin
                zero_run++;
            end
            if (!dut_if.busy) seen = 1'b0;
            if (dut_if.done) begin done_cnt++; done_cyc = cyc; end
            if (prev_busy && !dut_if.busy) busy_fall_cyc = cyc;
            prev_busy = dut_if.busy;
            prev_en   = dut_if.stage_en;
        end
    end

    // ---------------- stimulus helpers (all start and end at a falling edge) ----------------
    task automatic wait_en(input int k);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (dut_if.stage_en[k] === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_stage%0d: enable still low after 200 cycles, required high", k);
        end
    endtask

    task automatic finish_stage(input int k, input int hi);
        wait_en(k);
        repeat (hi - 1) @(negedge clk);
        dut_if.stage_fin = fin_base | (N'(1) << k);
        @(negedge clk);
        dut_if.stage_fin = fin_base;
    endtask

    task automatic start_seq();
        dut_if.en    = 1'b1;
        dut_if.start = 1'b1;
        @(negedge clk);
        dut_if.start   = 1'b0;
        dut_if.load_we = 1'b1;
        repeat (3) @(negedge clk);
        dut_if.load_we = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (dut_if.busy === 1'b0) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_idle: busy still high after 400 cycles, required low");
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic run_seq(input int hi);
        start_seq();
        for (int k = 0; k < N; k++) if (!fin_base[k]) finish_stage(k, hi);
        wait_idle();
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not reach the end, required finish");
        $fatal(1);
    end

    int d0;

    initial begin
        dut_if.en = 1'b0; dut_if.start = 1'b0; dut_if.load_we = 1'b0; dut_if.abort = 1'b0;
        dut_if.gap_cycles = 16'd3; dut_if.tmo_cycles = 32'd0;
        fin_base = N'(5'b01000);               // layer 3 fin stuck high from reset
        dut_if.stage_fin = fin_base;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stage_en", int'(dut_if.stage_en), 0);
        chk("rst_cur_stage", int'(dut_if.cur_stage), 0);
        chk("rst_busy", int'(dut_if.busy), 0);
        chk("rst_done", int'(dut_if.done), 0);
        chk("rst_error", int'(dut_if.error), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Stuck fin on layer 3: earlier layers unaffected, layer 3 enabled for one cycle only.
        run_seq(10);
        chk("hold_len0", hi_len[0], 10);
        chk("hold_len2", hi_len[2], 10);
        chk("hold_len3", hi_len[3], 1);
        chk("hold_len4", hi_len[4], 10);

        // Main sequence: 3-cycle gaps, 10-cycle layers, one done pulse, busy drops right after.
        fin_base = '0; dut_if.stage_fin = '0;
        gaps.delete(); d0 = done_cnt;
        run_seq(10);
        chk("main_gap_count", gaps.size(), 4);
        foreach (gaps[i]) chk("main_gap_len", gaps[i], 3);
        for (int k = 0; k < N; k++) chk("main_en_len", hi_len[k], 10);
        chk("main_done_pulses", done_cnt - d0, 1);
        chk("main_busy_after_done", busy_fall_cyc - done_cyc, 1);

        // Back-to-back layers: next enable rises on the edge the previous one falls.
        dut_if.gap_cycles = 16'd0;
        gaps.delete();
        start_seq();
        for (int k = 0; k < N - 1; k++) begin
            finish_stage(k, 4);
            #1;
            chk("gap0_handoff", int'(dut_if.stage_en), int'(N'(1) << (k + 1)));
        end
        finish_stage(N - 1, 4);
        wait_idle();
        chk("gap0_gap_count", gaps.size(), 4);
        foreach (gaps[i]) chk("gap0_gap_len", gaps[i], 0);

        // Asynchronous reset in the middle of a run.
        start_seq();
        finish_stage(0, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_stage_en", int'(dut_if.stage_en), 0);
        chk("arst_busy", int'(dut_if.busy), 0);
        chk("arst_cur_stage", int'(dut_if.cur_stage), 0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        run_seq(3);
        chk("arst_rerun_done", done_cnt - d0, 1);

        // Abort during the gap after layer 1, then a clean rerun.
        dut_if.gap_cycles = 16'd3;
        d0 = done_cnt;
        start_seq();
        finish_stage(0, 5);
        finish_stage(1, 5);
        dut_if.abort = 1'b1;
        @(negedge clk);
        dut_if.abort = 1'b0;
        #1;
        chk("abort_busy", int'(dut_if.busy), 0);
        chk("abort_stage_en", int'(dut_if.stage_en), 0);
        repeat (6) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        dut_if.gap_cycles = 16'd1;
        run_seq(4);
        chk("abort_rerun_done", done_cnt - d0, 1);
        chk("abort_rerun_len0", hi_len[0], 4);

        // Start while busy and start with en low are both ignored.
        start_seq();
        wait_en(0);
        dut_if.start = 1'b1;
        @(negedge clk);
        dut_if.start = 1'b0;
        #1;
        chk("busy_start_stage_en", int'(dut_if.stage_en), 1);
        chk("busy_start_cur", int'(dut_if.cur_stage), 0);
        for (int k = 0; k < N; k++) finish_stage(k, 3);
        wait_idle();
        dut_if.en = 1'b0; dut_if.start = 1'b1;
        @(negedge clk);
        dut_if.start = 1'b0;
        @(negedge clk);
        #1;
        chk("en_low_start_busy", int'(dut_if.busy), 0);

        // Watchdog: layer 2 never finishes with a 20-cycle limit.
        dut_if.gap_cycles = 16'd2; dut_if.tmo_cycles = 32'd20;
        start_seq();
        finish_stage(0, 3);
        finish_stage(1, 3);
        wait_en(2);
        repeat (19) @(negedge clk);
        #1;
        chk("wdog_before_err", int'({dut_if.stage_en, dut_if.error}), int'({N'(5'b00100), 1'b0}));
        @(negedge clk);
        #1;
        chk("wdog_error", int'(dut_if.error), int'(WDOG));
        chk("wdog_stage_en", int'(dut_if.stage_en), WDOG ? 0 : 4);
        chk("wdog_cur_stage", int'(dut_if.cur_stage), 2);
        dut_if.en = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("wdog_en_low_busy", int'(dut_if.busy), int'(!WDOG));
        chk("wdog_error_sticky", int'(dut_if.error), int'(WDOG));
        dut_if.abort = 1'b1;
        @(negedge clk);
        dut_if.abort = 1'b0;
        start_seq();
        #1;
        chk("wdog_start_clears", int'({dut_if.busy, dut_if.error}), 2);
        for (int k = 0; k < N; k++) finish_stage(k, 3);
        wait_idle();
        dut_if.tmo_cycles = 32'd0;

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
